// File: rtl/des_round_ctrl.sv
// DES round sequencer: loads the datapath, steps 16 Feistel rounds with key-schedule
// rotate amounts, performs the final half swap and holds the result until accepted.
module des_round_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             decrypt,
   input  logic             abort,
   input  logic             out_ready,
   output logic             in_ready,
   output logic             load,
   output logic             round_en,
   output logic [3:0]       round_idx,
   output logic [1:0]       key_shift,
   output logic             key_dir,
   output logic             final_swap,
   output logic             out_valid,
   output logic             busy,
   output logic [CNT_W-1:0] blk_cnt
);

   localparam int unsigned IDX_W = 4;
   localparam int unsigned KS_W  = 2;
   localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(15);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ROUND = 3'd2,
      S_FINAL = 3'd3,
      S_OUTV  = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_mode;
   logic               w_mode_nxt;
   logic [IDX_W-1:0]   r_round_idx;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic               w_cnt_inc;
   logic [CNT_W-1:0]   r_blk_cnt;
   logic               r_in_ready;
   logic               r_busy;
   logic               r_load;
   logic               r_round_en;
   logic               r_final_swap;
   logic               r_out_valid;
   logic [KS_W-1:0]    r_key_shift;

   // Key-half rotate amount for a round; decrypt skips the rotate before its first round.
   function automatic logic [KS_W-1:0] f_key_shift(input logic             rnd,
                                                   input logic             dec,
                                                   input logic [IDX_W-1:0] idx);
      logic [KS_W-1:0] ks;
      ks = KS_W'(0);
      if (rnd) begin
         if (dec && (idx == IDX_W'(0))) begin
            ks = KS_W'(0);
         end else if ((idx == IDX_W'(0)) || (idx == IDX_W'(1)) ||
                      (idx == IDX_W'(8)) || (idx == LAST_ROUND)) begin
            ks = KS_W'(1);
         end else begin
            ks = KS_W'(2);
         end
      end
      return ks;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, mode latch, round counter and completion strobe.
   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_idx_nxt   = IDX_W'(0);
      w_cnt_inc   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start && !abort) begin
               w_state_nxt = S_LOAD;
               w_mode_nxt  = decrypt;
            end
         end
         S_LOAD: begin
            w_state_nxt = S_ROUND;
         end
         S_ROUND: begin
            if (r_round_idx == LAST_ROUND) begin
               w_state_nxt = S_FINAL;
            end
         end
         S_FINAL: begin
            w_state_nxt = S_OUTV;
         end
         S_OUTV: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
               w_cnt_inc   = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Cancel wins over everything, including an accepted result.
      if (abort && (r_state != S_IDLE)) begin
         w_state_nxt = S_IDLE;
         w_cnt_inc   = 1'b0;
      end

      if ((r_state == S_ROUND) && (w_state_nxt == S_ROUND)) begin
         w_idx_nxt = r_round_idx + IDX_W'(1);
      end
   end

   // Outputs are registered from the next-state decode so they change only on clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mode       <= 1'b0;
         r_round_idx  <= IDX_W'(0);
         r_blk_cnt    <= CNT_W'(0);
         r_in_ready   <= 1'b1;
         r_busy       <= 1'b0;
         r_load       <= 1'b0;
         r_round_en   <= 1'b0;
         r_final_swap <= 1'b0;
         r_out_valid  <= 1'b0;
         r_key_shift  <= KS_W'(0);
      end else begin
         r_mode       <= w_mode_nxt;
         r_round_idx  <= w_idx_nxt;
         if (w_cnt_inc) begin
            r_blk_cnt <= r_blk_cnt + CNT_W'(1);
         end
         r_in_ready   <= (w_state_nxt == S_IDLE);
         r_busy       <= (w_state_nxt != S_IDLE);
         r_load       <= (w_state_nxt == S_LOAD);
         r_round_en   <= (w_state_nxt == S_ROUND);
         r_final_swap <= (w_state_nxt == S_FINAL);
         r_out_valid  <= (w_state_nxt == S_OUTV);
         r_key_shift  <= f_key_shift(w_state_nxt == S_ROUND, w_mode_nxt, w_idx_nxt);
      end
   end

   assign in_ready   = r_in_ready;
   assign busy       = r_busy;
   assign load       = r_load;
   assign round_en   = r_round_en;
   assign round_idx  = r_round_idx;
   assign key_shift  = r_key_shift;
   assign key_dir    = r_mode;
   assign final_swap = r_final_swap;
   assign out_valid  = r_out_valid;
   assign blk_cnt    = r_blk_cnt;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Scoreboard bench for des_round_ctrl: stimulus queues expected strobe events, a negedge
// monitor pops and compares them as the DUT produces load/round/final/valid/handshake.
module tb_des_round_ctrl;

   localparam int K_LOAD  = 0;
   localparam int K_ROUND = 1;
   localparam int K_FINAL = 2;
   localparam int K_VALID = 3;
   localparam int K_DONE  = 4;

   typedef struct {
      int kind;
      int cyc;
      int idx;
      int shift;
      int dir;
      int cnt;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst, start, decrypt, abort, out_ready;
   logic        in_ready, load, round_en, key_dir, final_swap, out_valid, busy;
   logic [3:0]  round_idx;
   logic [1:0]  key_shift;
   logic [15:0] blk_cnt;
   logic        in_ready2, load2, round_en2, key_dir2, final_swap2, out_valid2, busy2;
   logic [3:0]  round_idx2;
   logic [1:0]  key_shift2;
   logic [1:0]  blk_cnt2;

   int  cyc      = 0;
   int  n_tests  = 0;
   int  n_fail   = 0;
   int  exp_cnt  = 0;
   bit  pend     = 1'b0;
   int  pend_cnt = 0;
   ev_t q[$];

   int enc_ks[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   int dec_ks[16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   des_round_ctrl u_dut (
      .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .abort(abort),
      .out_ready(out_ready), .in_ready(in_ready), .load(load), .round_en(round_en),
      .round_idx(round_idx), .key_shift(key_shift), .key_dir(key_dir),
      .final_swap(final_swap), .out_valid(out_valid), .busy(busy), .blk_cnt(blk_cnt)
   );

   des_round_ctrl #(.CNT_W(2)) u_dut_w2 (
      .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .abort(abort),
      .out_ready(out_ready), .in_ready(in_ready2), .load(load2), .round_en(round_en2),
      .round_idx(round_idx2), .key_shift(key_shift2), .key_dir(key_dir2),
      .final_swap(final_swap2), .out_valid(out_valid2), .busy(busy2), .blk_cnt(blk_cnt2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic void push_ev(int k, int c, int i, int s, int d, int n);
      ev_t e;
      e.kind = k; e.cyc = c; e.idx = i; e.shift = s; e.dir = d; e.cnt = n;
      q.push_back(e);
   endfunction

   // Expected events of a block started at cycle c0, truncated after cycle 'last'.
   function automatic void push_block(int c0, logic dec, int bp, int last, bit done);
      if (c0 + 1 <= last) push_ev(K_LOAD, c0 + 1, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         if (c0 + 2 + i <= last)
            push_ev(K_ROUND, c0 + 2 + i, i, dec ? dec_ks[i] : enc_ks[i], int'(dec), 0);
      end
      if (c0 + 18 <= last) push_ev(K_FINAL, c0 + 18, 0, 0, 0, 0);
      for (int v = 0; v <= bp; v++) begin
         if (c0 + 19 + v <= last) push_ev(K_VALID, c0 + 19 + v, 0, 0, 0, 0);
      end
      if (done) begin
         exp_cnt++;
         push_ev(K_DONE, c0 + 19 + bp, 0, 0, 0, exp_cnt);
      end
   endfunction

   task automatic observe(input int kind);
      ev_t e;
      if (q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
      end else begin
         e = q.pop_front();
         chk("ev_kind", kind, e.kind);
         chk("ev_cycle", cyc, e.cyc);
         if (kind == K_ROUND && e.kind == K_ROUND) begin
            chk("round_idx", round_idx, e.idx);
            chk("key_shift", key_shift, e.shift);
            chk("key_dir", key_dir, e.dir);
         end
         if (kind == K_DONE && e.kind == K_DONE) begin
            pend     = 1'b1;
            pend_cnt = e.cnt;
         end
      end
   endtask

   // Monitor: match DUT strobes against the expected-event queue.
   always @(negedge clk) begin
      if (rst) begin
         if (pend) begin
            chk("blk_cnt", blk_cnt, pend_cnt % 65536);
            chk("blk_cnt_w2", blk_cnt2, pend_cnt % 4);
            pend = 1'b0;
         end
         if (!round_en) chk("key_shift_idle", key_shift, 0);
         if (load)       observe(K_LOAD);
         if (round_en)   observe(K_ROUND);
         if (final_swap) observe(K_FINAL);
         if (out_valid)  observe(K_VALID);
         if (out_valid && out_ready && !abort) observe(K_DONE);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_check(input string nm, input logic mode);
      chk({nm, ".in_ready"}, in_ready, 1);
      chk({nm, ".busy"}, busy, 0);
      chk({nm, ".load"}, load, 0);
      chk({nm, ".round_en"}, round_en, 0);
      chk({nm, ".final_swap"}, final_swap, 0);
      chk({nm, ".out_valid"}, out_valid, 0);
      chk({nm, ".key_shift"}, key_shift, 0);
      chk({nm, ".key_dir"}, key_dir, mode);
      chk({nm, ".blk_cnt"}, blk_cnt, exp_cnt % 65536);
      chk({nm, ".blk_cnt_w2"}, blk_cnt2, exp_cnt % 4);
   endtask

   // Full block with bp stalled OUTV cycles; stray start pulses and decrypt flips mid-block.
   task automatic run_block(input logic dec, input int bp);
      int c0;
      c0 = cyc;
      push_block(c0, dec, bp, c0 + 19 + bp, 1'b1);
      start = 1'b1; decrypt = dec; out_ready = 1'b0;
      for (int k = 1; k <= 19 + bp; k++) begin
         tick();
         start     = (k == 5) || (k >= 19 && k < 19 + bp);
         decrypt   = ~dec;
         out_ready = (k == 19 + bp);
      end
      tick();
      start = 1'b0; out_ready = 1'b0; decrypt = 1'b0;
   endtask

   // Block cancelled by abort raised (with out_ready) in cycle c0+ab_k.
   task automatic run_abort(input string nm, input logic dec, input int ab_k);
      int c0;
      c0 = cyc;
      push_block(c0, dec, 0, c0 + ab_k, 1'b0);
      start = 1'b1; decrypt = dec;
      for (int k = 1; k <= ab_k; k++) begin
         tick();
         start     = 1'b0;
         abort     = (k == ab_k);
         out_ready = (k == ab_k);
      end
      tick();
      abort = 1'b0; out_ready = 1'b0;
      idle_check(nm, dec);
   endtask

   initial begin
      int c0;
      rst = 1'b1; start = 1'b0; decrypt = 1'b0; abort = 1'b0; out_ready = 1'b0;
      #2 rst = 1'b0;
      #1 idle_check("in_reset", 1'b0);
      chk("in_reset.round_idx", round_idx, 0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      idle_check("after_reset", 1'b0);

      run_block(1'b0, 0);
      run_block(1'b1, 0);
      run_block(1'b0, 5);

      run_abort("abort_round7", 1'b0, 9);
      run_abort("abort_outv_ready", 1'b1, 19);

      // start together with abort in IDLE must not launch a block or latch the mode.
      start = 1'b1; abort = 1'b1; decrypt = 1'b0;
      tick();
      start = 1'b0; abort = 1'b0;
      idle_check("abort_start_idle", 1'b1);
      tick();
      idle_check("abort_start_idle2", 1'b1);

      run_block(1'b1, 2);

      // Reset asserted while round_idx=10 of a decrypt block.
      c0 = cyc;
      push_block(c0, 1'b1, 0, c0 + 11, 1'b0);
      start = 1'b1; decrypt = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         start = 1'b0;
      end
      chk("pre_rst.round_idx", round_idx, 10);
      rst = 1'b0;
      exp_cnt = 0;
      #1 idle_check("rst_mid", 1'b0);
      chk("rst_mid.round_idx", round_idx, 0);
      tick();
      rst = 1'b1;
      tick();
      idle_check("rst_release", 1'b0);

      run_block(1'b0, 0);
      run_block(1'b1, 0);
      run_block(1'b0, 1);
      run_block(1'b0, 0);

      tick();
      tick();
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
